uc_multiciclo: RTL and testbench
================================

UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port Opcode, input, 6: instruction[15:10] from the datapath instruction memory.
REQ-005 SHALL have port zero, input, 1: registered zero flag from the datapath.
REQ-006 SHALL have port stall, input, 1: freezes the FSM while high.
REQ-007 SHALL have ports s_inc, s_inm, we, wez, outputs, 1 each: datapath controls (1 = PC+1, 1 = immediate, register write, flag write).
REQ-008 SHALL have port ALUOp, output, 3: ALU operation select.
REQ-009 SHALL have port pc_en, output, 1: PC register load enable.
REQ-010 SHALL have port halted, output, 1: high in HALT state.
REQ-011 SHALL have port retired, output, CNT_W: count of completed instructions.

Function
REQ-012 SHALL implement FSM states FETCH, EXEC (plus HALT when enabled); FETCH->EXEC->FETCH, one cycle each when stall=0.
REQ-013 FETCH SHALL drive we=wez=pc_en=0, s_inc=1, s_inm=0, ALUOp=000; synchronous program memory read completes here.
REQ-014 EXEC SHALL decode Opcode and assert pc_en=1 for exactly that cycle.
REQ-015 Opcode 1aaaxx: ALUOp=aaa, s_inm=0, we=1, wez=1, s_inc=1.
REQ-016 Opcode 01xxxx: load immediate; s_inm=1, ALUOp=000 (pass B), we=1, wez=0, s_inc=1.
REQ-017 Opcode 000000 (J): s_inc=0, we=wez=0.
REQ-018 Opcode 000001 (JZ): s_inc=~zero; 000010 (JNZ): s_inc=zero; we=wez=0.
REQ-019 Opcode 000011 and all 001xxx not otherwise defined: NOP; s_inc=1, we=wez=0.
REQ-020 zero SHALL be sampled in the EXEC cycle only; a wez write in the same EXEC cycle is not visible until the next instruction.
REQ-021 retired SHALL increment by 1 at the end of each EXEC cycle with stall=0; wraps from 2^CNT_W-1 to 0.
REQ-022 stall=1 SHALL hold state and retired and force we=wez=pc_en=0 that cycle; s_inc/s_inm/ALUOp unchanged.
REQ-023 stall asserted during EXEC SHALL repeat EXEC on the next unstalled cycle with the same Opcode.

Reset
REQ-024 reset=1 SHALL immediately force state FETCH, retired=0, halted=0, and outputs per REQ-013, regardless of clk.
REQ-025 Reset mid-EXEC SHALL suppress that cycle's we/wez/pc_en; no partial instruction retires.

Configuration
REQ-026 With UC_HALT_EN defined, Opcode 001111 in EXEC SHALL enter HALT: pc_en=we=wez=0, halted=1, retired counts the HALT once, exit only via reset.
REQ-027 Without UC_HALT_EN, 001111 SHALL be a NOP and halted SHALL be constant 0.

Structure
REQ-028 State encoding, opcode constants (OP_J, OP_JZ, OP_JNZ, OP_NOP, OP_HALT) and ALUOp pass-B value SHALL live in a shared package uc_pkg.
REQ-029 Opcode decoding SHALL be a combinational sub-module uc_decode; uc_multiciclo holds the FSM, counter and stall/reset gating.

Verification
REQ-030 Reset then Opcode=100100 (ALUOp 001), stall=0 -> cycle1 FETCH all enables 0; cycle2 ALUOp=001, we=wez=pc_en=1; retired=1.
REQ-031 Opcode=000001 with zero=1 -> EXEC s_inc=0; with zero=0 -> s_inc=1; we=wez=0 both cases.
REQ-032 Opcode=010000 with stall=1 in EXEC for 3 cycles -> we=pc_en=0 for 3 cycles, then one EXEC with we=1, s_inm=1; retired +1 only.
REQ-033 CNT_W=4, 16 instructions from reset -> retired returns to 0.
REQ-034 UC_HALT_EN, Opcode=001111 -> halted=1, pc_en=0 for 10 cycles; assert reset -> halted=0 same cycle; without macro -> NOP, halted=0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared constants for the multicycle control unit: state encoding, opcodes, ALU selects.
package uc_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [5:0] OP_J    = 6'b000000;
  localparam logic [5:0] OP_JZ   = 6'b000001;
  localparam logic [5:0] OP_JNZ  = 6'b000010;
  localparam logic [5:0] OP_NOP  = 6'b000011;
  localparam logic [5:0] OP_HALT = 6'b001111;

  localparam logic [2:0] ALU_PASS_B = 3'b000;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder: datapath controls for the EXEC cycle, before stall gating.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl.s_inc  = 1'b1;
    ctrl.s_inm  = 1'b0;
    ctrl.we     = 1'b0;
    ctrl.wez    = 1'b0;
    ctrl.alu_op = ALU_PASS_B;
    if (opcode[5]) begin
      ctrl.alu_op = opcode[4:2];
      ctrl.we     = 1'b1;
      ctrl.wez    = 1'b1;
    end else if (opcode[4]) begin
      ctrl.s_inm = 1'b1;
      ctrl.we    = 1'b1;
    end else begin
      // OP_NOP, OP_HALT and the rest of 001xxx fall through as NOPs here
      case (opcode)
        OP_J:    ctrl.s_inc = 1'b0;
        OP_JZ:   ctrl.s_inc = ~zero;
        OP_JNZ:  ctrl.s_inc = zero;
        default: ctrl.s_inc = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Two-state multicycle control unit with retired-instruction counter and stall gating.
// Optional HALT state enabled by defining UC_HALT_EN.
//
// state    | meaning
// ST_FETCH | program memory read in progress, all write enables low
// ST_EXEC  | decode opcode, update PC and register file
// ST_HALT  | stopped until reset (UC_HALT_EN only)
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             stall,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic             wez,
  output logic [2:0]       ALUOp,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            dec;
  logic             is_halt;

  uc_decode u_decode (
    .opcode (Opcode),
    .zero   (zero),
    .ctrl   (dec)
  );

`ifdef UC_HALT_EN
  assign is_halt = (Opcode == OP_HALT);
  assign halted  = (state_q == ST_HALT);
`else
  assign is_halt = 1'b0;
  assign halted  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    if (!stall) begin
      case (state_q)
        ST_FETCH: state_d = ST_EXEC;
        ST_EXEC: begin
          retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d   = is_halt ? ST_HALT : ST_FETCH;
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Stall only masks the side effects; mux selects stay decoded so the datapath is stable.
  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we    = 1'b0;
    wez   = 1'b0;
    ALUOp = ALU_PASS_B;
    pc_en = 1'b0;
    if (state_q == ST_EXEC) begin
      s_inc = dec.s_inc;
      s_inm = dec.s_inm;
      ALUOp = dec.alu_op;
      we    = dec.we & ~stall;
      wez   = dec.wez & ~stall;
      pc_en = ~stall;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo: default-width and 4-bit counter instances share stimulus.
module tb_uc_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic        zero;
  logic        stall;

  logic        a_s_inc, a_s_inm, a_we, a_wez, a_pc_en, a_halted;
  logic [2:0]  a_alu;
  logic [15:0] a_ret;
  logic        b_s_inc, b_s_inm, b_we, b_wez, b_pc_en, b_halted;
  logic [2:0]  b_alu;
  logic [3:0]  b_ret;

`ifdef UC_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // ctrl pack: {s_inc, s_inm, we, wez, ALUOp, pc_en, halted}
  localparam logic [8:0] FETCH_CTRL = 9'b1_0_0_0_000_0_0;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [15:0] r16;
    logic [3:0]  r4;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_state;
  int unsigned m_ret;

  uc_multiciclo u_dut16 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .stall(stall),
    .s_inc(a_s_inc), .s_inm(a_s_inm), .we(a_we), .wez(a_wez), .ALUOp(a_alu),
    .pc_en(a_pc_en), .halted(a_halted), .retired(a_ret)
  );

  uc_multiciclo #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .stall(stall),
    .s_inc(b_s_inc), .s_inm(b_s_inm), .we(b_we), .wez(b_wez), .ALUOp(b_alu),
    .pc_en(b_pc_en), .halted(b_halted), .retired(b_ret)
  );

  always #5 clk = ~clk;

  wire [8:0] ctrl_a = {a_s_inc, a_s_inm, a_we, a_wez, a_alu, a_pc_en, a_halted};
  wire [8:0] ctrl_b = {b_s_inc, b_s_inm, b_we, b_wez, b_alu, b_pc_en, b_halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_ctrl(input int st, input logic [5:0] op,
                                            input logic z, input logic stl);
    logic       si, sm, w, wz, pe, h;
    logic [2:0] a;
    si = 1'b1; sm = 1'b0; w = 1'b0; wz = 1'b0; a = 3'b000; pe = 1'b0; h = 1'b0;
    if (st == 2) begin
      h = 1'b1;
    end else if (st == 1) begin
      pe = ~stl;
      if (op[5]) begin
        a = op[4:2]; w = 1'b1; wz = 1'b1;
      end else if (op[4]) begin
        sm = 1'b1; w = 1'b1;
      end else if (op == 6'b000000) begin
        si = 1'b0;
      end else if (op == 6'b000001) begin
        si = ~z;
      end else if (op == 6'b000010) begin
        si = z;
      end
      if (stl) begin
        w = 1'b0; wz = 1'b0;
      end
    end
    return {si, sm, w, wz, a, pe, h};
  endfunction

  // Called at posedge+1: drive, queue expectation, compare at negedge, advance model at posedge.
  task automatic cyc(input logic [5:0] op, input logic z, input logic stl);
    exp_t e, g;
    Opcode = op; zero = z; stall = stl;
    e.ctrl = model_ctrl(m_state, op, z, stl);
    e.r16  = m_ret[15:0];
    e.r4   = m_ret[3:0];
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk("ctrl16", {23'd0, ctrl_a}, {23'd0, g.ctrl});
    chk("ctrl4", {23'd0, ctrl_b}, {23'd0, g.ctrl});
    chk("ret16", {16'd0, a_ret}, {16'd0, g.r16});
    chk("ret4", {28'd0, b_ret}, {28'd0, g.r4});
    @(posedge clk);
    if (!stl) begin
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
        m_ret++;
        m_state = (HALT_EN && op == 6'b001111) ? 2 : 0;
      end
    end
    #1;
  endtask

  // Called at posedge+1: asynchronous reset asserted mid-cycle, effect checked before any edge.
  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_ctrl"}, {23'd0, ctrl_a}, {23'd0, FETCH_CTRL});
    chk({tag, "_halt"}, {31'd0, a_halted}, 32'd0);
    chk({tag, "_ret"}, {16'd0, a_ret}, 32'd0);
    chk({tag, "_ret4"}, {28'd0, b_ret}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_state = 0;
    m_ret   = 0;
  endtask

  initial begin
    int unsigned r0;
    reset = 1'b1; Opcode = 6'b100100; zero = 1'b0; stall = 1'b0;
    m_state = 0; m_ret = 0;
    #2;
    chk("rst_ctrl", {23'd0, ctrl_a}, {23'd0, FETCH_CTRL});
    chk("rst_ret", {16'd0, a_ret}, 32'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;

    // ALU op 001: FETCH with enables low, then EXEC writes
    cyc(6'b100100, 1'b0, 1'b0);
    cyc(6'b100100, 1'b0, 1'b0);
    chk("alu_ret", {16'd0, a_ret}, 32'd1);

    // conditional jumps and unconditional jump
    cyc(6'b000001, 1'b1, 1'b0); cyc(6'b000001, 1'b1, 1'b0);
    cyc(6'b000001, 1'b0, 1'b0); cyc(6'b000001, 1'b0, 1'b0);
    cyc(6'b000010, 1'b1, 1'b0); cyc(6'b000010, 1'b1, 1'b0);
    cyc(6'b000010, 1'b0, 1'b0); cyc(6'b000010, 1'b0, 1'b0);
    cyc(6'b000000, 1'b0, 1'b0); cyc(6'b000000, 1'b0, 1'b0);
    cyc(6'b000011, 1'b1, 1'b0); cyc(6'b000011, 1'b1, 1'b0);
    cyc(6'b111100, 1'b0, 1'b0); cyc(6'b111100, 1'b0, 1'b0);

    // load immediate stalled three cycles in EXEC
    r0 = m_ret;
    cyc(6'b010000, 1'b0, 1'b0);
    cyc(6'b010000, 1'b0, 1'b1);
    cyc(6'b010000, 1'b0, 1'b1);
    cyc(6'b010000, 1'b0, 1'b1);
    chk("stall_hold", {16'd0, a_ret}, r0);
    cyc(6'b010000, 1'b0, 1'b0);
    chk("stall_ret", {16'd0, a_ret}, r0 + 1);
    cyc(6'b010000, 1'b0, 1'b1);

    // reset while in EXEC with a writing opcode
    cyc(6'b100000, 1'b0, 1'b0);
    Opcode = 6'b100000; stall = 1'b0;
    mid_reset("rst_exec");

    // 16 instructions wrap the 4-bit counter
    for (int i = 0; i < 32; i++) cyc(6'b101000, 1'b0, 1'b0);
    chk("wrap4", {28'd0, b_ret}, 32'd0);
    chk("wrap16", {16'd0, a_ret}, 32'd16);

    // HALT opcode: halts when enabled, NOP otherwise
    cyc(6'b001111, 1'b0, 1'b0);
    cyc(6'b001111, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(6'b001111, 1'b0, 1'b0);
    chk("halt_flag", {31'd0, a_halted}, {31'd0, HALT_EN});
    mid_reset("rst_halt");

    for (int i = 0; i < 300; i++)
      cyc(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    mid_reset("rst_end");

    if (sb.size() != 0) chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
